// File: rtl/ram_sdp_param.sv
// ram_sdp_param: simple-dual-port synchronous RAM with one shared clock.
// Provides a configurable width/depth, a read latency of 1 or 2 cycles, a
// selectable collision mode, a read-valid strobe and out-of-range address
// detection. After every reset a hardware sweep zeroes the whole array,
// and no requests are accepted until that sweep completes.
module ram_sdp_param #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              addr_err
);

  // The array index width can be narrower than the address port.
  // Out-of-range addresses are rejected before any array access, so
  // narrowing the address to this width never aliases two locations.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH can equal 2**ADDR_W, so the range compare uses one extra bit.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_busy;
  logic                r_addr_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                r_s1_valid;
  logic [DATA_W-1:0]   r_s1_data;

  logic                w_clr_we;
  logic                w_accept;
  logic                w_clr_last;
  logic                w_wr_in;
  logic                w_rd_in;
  logic                w_wr_do;
  logic                w_rd_do;
  logic                w_collide;
  logic [DATA_W-1:0]   w_s1_data;

  assign w_clr_last = (r_clr_ptr == CLR_LAST);

  // Range checks use only the comparison with DEPTH.
  // Addresses are neither truncated nor wrapped.
  assign w_wr_in   = ({1'b0, write_addr} < DEPTH_L);
  assign w_rd_in   = ({1'b0, read_addr}  < DEPTH_L);
  assign w_wr_do   = w_accept & write_en & w_wr_in;
  assign w_rd_do   = w_accept & read_en;
  assign w_collide = w_wr_do & read_en & w_rd_in & (write_addr == read_addr);

  // Selects the result launched into the pipeline.
  // An out-of-range or absent read launches 0. A write-first collision
  // bypasses the write data; otherwise the array returns its old contents.
  assign w_s1_data = (w_rd_do && w_rd_in)
                   ? (((WR_FIRST != 0) && w_collide) ? write_data : r_mem[IDX_W'(read_addr)])
                   : '0;

  // Holds the control state, the sweep pointer and the busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_CLEAR);
      if (w_clr_we) begin
        r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
      end
    end
  end

  // Next-state logic: the sweep leaves CLEAR once it has written the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: CLEAR drives the sweep writes, and IDLE is the only
  // state that accepts requests.
  always_comb begin
    w_clr_we = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ST_CLEAR: w_clr_we = 1'b1;
      ST_IDLE:  w_accept = 1'b1;
      default:  ;
    endcase
  end

  // Storage array: sweep zeroes have priority; user writes are accepted only when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[IDX_W'(r_clr_ptr)] <= '0;
      end else if (w_wr_do) begin
        r_mem[IDX_W'(write_addr)] <= write_data;
      end
    end
  end

  // First read stage and addr_err.
  // Both are registered on the edge that samples the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_do;
      r_s1_data  <= w_s1_data;
      r_addr_err <= w_accept & ((write_en & ~w_wr_in) | (read_en & ~w_rd_in));
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;

      // Extra output register for the two-cycle read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= r_s1_data;
        end
      end

      assign read_valid = r_s2_valid;
      assign read_data  = r_s2_data;
    end else begin : g_lat1
      assign read_valid = r_s1_valid;
      assign read_data  = r_s1_data;
    end
  endgenerate

  assign busy     = r_busy;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_ram_sdp_param.sv
// tb_ram_sdp_param: drives three differently parameterised RAM instances
// from one shared stimulus. The instances are:
//   dut0: DEPTH 8, RD_LAT 1, read-old-data on collision
//   dut1: DEPTH 8, RD_LAT 2, write-first on collision
//   dut2: DEPTH 6, ADDR_W 3, RD_LAT 1, read-old-data on collision
// The bench checks all three against directed constants and against a
// behavioural reference model.
`timescale 1ns/1ps
module tb_ram_sdp_param;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [7:0] write_addr;
  logic [3:0] write_data;
  logic       read_en;
  logic [7:0] read_addr;

  logic [3:0] rdata  [NDUT];
  logic       rvalid [NDUT];
  logic       busy   [NDUT];
  logic       aerr   [NDUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sdp_param #(.DATA_W(4), .ADDR_W(8), .DEPTH(8), .RD_LAT(1), .WR_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rdata[0]), .read_valid(rvalid[0]), .busy(busy[0]), .addr_err(aerr[0])
  );

  ram_sdp_param #(.DATA_W(4), .ADDR_W(8), .DEPTH(8), .RD_LAT(2), .WR_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(rdata[1]), .read_valid(rvalid[1]), .busy(busy[1]), .addr_err(aerr[1])
  );

  ram_sdp_param #(.DATA_W(4), .ADDR_W(3), .DEPTH(6), .RD_LAT(1), .WR_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr[2:0]), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr[2:0]),
    .read_data(rdata[2]), .read_valid(rvalid[2]), .busy(busy[2]), .addr_err(aerr[2])
  );

  function automatic int unsigned dep_of(int k);
    return (k == 2) ? 6 : 8;
  endfunction

  function automatic int unsigned aw_of(int k);
    return (k == 2) ? 3 : 8;
  endfunction

  function automatic int unsigned lat_of(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic logic wf_of(int k);
    return (k == 1);
  endfunction

  // ---------------------------------------------------------------
  // Reference model.
  // It works at the level of the rules: memory contents, a count of
  // busy edges left after reset, and a delay line of read results.
  // ---------------------------------------------------------------
  logic [3:0]  m_mem  [NDUT][256];
  int unsigned m_left [NDUT];
  logic        m_pv   [NDUT];
  logic [3:0]  m_pd   [NDUT];
  logic        e_valid[NDUT];
  logic [3:0]  e_data [NDUT];
  logic        e_busy [NDUT];
  logic        e_err  [NDUT];

  task automatic model_edge();
    int unsigned wa, ra, dep;
    logic        idle, rv;
    logic [3:0]  rd;
    for (int k = 0; k < NDUT; k++) begin
      dep = dep_of(k);
      wa  = 32'(write_addr) % (32'd1 << aw_of(k));
      ra  = 32'(read_addr)  % (32'd1 << aw_of(k));
      if (rst) begin
        m_left[k] = dep;
        for (int a = 0; a < 256; a++) m_mem[k][a] = 4'h0;
        m_pv[k]    = 1'b0;
        m_pd[k]    = 4'h0;
        e_valid[k] = 1'b0;
        e_data[k]  = 4'h0;
        e_busy[k]  = 1'b1;
        e_err[k]   = 1'b0;
      end else begin
        idle = (m_left[k] == 0);
        if (!idle) m_left[k] = m_left[k] - 1;
        rv = idle && read_en;
        rd = 4'h0;
        if (rv && ra < dep) begin
          rd = (wf_of(k) && write_en && wa == ra) ? write_data : m_mem[k][ra];
        end
        e_err[k] = idle && ((write_en && wa >= dep) || (read_en && ra >= dep));
        if (idle && write_en && wa < dep) m_mem[k][wa] = write_data;
        e_busy[k] = (m_left[k] != 0);
        if (lat_of(k) == 1) begin
          e_valid[k] = rv;
          e_data[k]  = rd;
        end else begin
          e_valid[k] = m_pv[k];
          e_data[k]  = m_pd[k];
        end
        m_pv[k] = rv;
        m_pd[k] = rd;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      m_left[k] = 0;
      m_pv[k]   = 1'b0;
      m_pd[k]   = 4'h0;
      for (int a = 0; a < 256; a++) m_mem[k][a] = 4'h0;
    end
  end

  always @(posedge clk) model_edge();

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_addr = 8'd0;
    read_addr  = 8'd0;
    write_data = 4'h0;
  endtask

  // Reset values, busy length after a 1-cycle rst, and reads returning 0 after the sweep.
  task automatic test_reset();
    int cnt [NDUT];
    rst = 1'b1;
    tick();
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (busy[d] !== 1'b1 || rvalid[d] !== 1'b0 || rdata[d] !== 4'h0 || aerr[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_vals dut%0d: got busy=%b valid=%b data=%h err=%b, want 1 0 0 0",
                 d, busy[d], rvalid[d], rdata[d], aerr[d]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    for (int a = 0; a < 8; a++) begin
      write_en = 1'b1; write_addr = 8'(a); write_data = 4'hF;
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) cnt[d] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < NDUT; d++) if (busy[d] === 1'b1) cnt[d]++;
      tick();
    end
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (cnt[d] != int'(dep_of(d))) begin
        n_err++;
        $display("FAIL busy_len dut%0d: got %0d cycles, want %0d", d, cnt[d], dep_of(d));
      end
    end
    for (int a = 0; a < 8; a++) begin
      read_en = 1'b1; read_addr = 8'(a);
      tick();
      n_vec++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 4'h0) begin
        n_err++;
        $display("FAIL clear_read dut0 addr%0d: got valid=%b data=%h, want 1 0", a, rvalid[0], rdata[0]);
      end
      if (a < 6) begin
        n_vec++;
        if (rvalid[2] !== 1'b1 || rdata[2] !== 4'h0) begin
          n_err++;
          $display("FAIL clear_read dut2 addr%0d: got valid=%b data=%h, want 1 0", a, rvalid[2], rdata[2]);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  // Latency-1 write followed by read, then read_data returns to 0.
  task automatic test_basic_rw();
    write_en = 1'b1; write_addr = 8'd3; write_data = 4'hA;
    tick();
    write_en = 1'b0; read_en = 1'b1; read_addr = 8'd3;
    tick();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 4'hA) begin
      n_err++;
      $display("FAIL basic_read dut0: got valid=%b data=%h, want 1 a", rvalid[0], rdata[0]);
    end
    read_en = 1'b0;
    tick();
    n_vec++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 4'h0) begin
      n_err++;
      $display("FAIL basic_idle dut0: got valid=%b data=%h, want 0 0", rvalid[0], rdata[0]);
    end
  endtask

  // Latency-2 streaming: eight consecutive valids holding 1..8.
  task automatic test_stream_lat2();
    logic       ev;
    logic [3:0] ed;
    for (int a = 0; a < 8; a++) begin
      write_en = 1'b1; write_addr = 8'(a); write_data = 4'(a + 1);
      tick();
    end
    idle_inputs();
    tick();
    for (int i = 0; i < 10; i++) begin
      read_en   = (i < 8);
      read_addr = 8'(i % 8);
      tick();
      ev = (i >= 1 && i <= 8);
      ed = ev ? 4'(i) : 4'h0;
      n_vec++;
      if (rvalid[1] !== ev || rdata[1] !== ed) begin
        n_err++;
        $display("FAIL stream dut1 step%0d: got valid=%b data=%h, want %b %h", i, rvalid[1], rdata[1], ev, ed);
      end
    end
    idle_inputs();
  endtask

  // Collision at address 5: old data or bypass depending on mode, then the new value.
  task automatic test_collision();
    write_en = 1'b1; write_addr = 8'd5; write_data = 4'h2;
    tick();
    write_data = 4'h9; read_en = 1'b1; read_addr = 8'd5;
    tick();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 4'h2) begin
      n_err++;
      $display("FAIL collide_old dut0: got valid=%b data=%h, want 1 2", rvalid[0], rdata[0]);
    end
    n_vec++;
    if (rvalid[2] !== 1'b1 || rdata[2] !== 4'h2) begin
      n_err++;
      $display("FAIL collide_old dut2: got valid=%b data=%h, want 1 2", rvalid[2], rdata[2]);
    end
    idle_inputs();
    tick();
    n_vec++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 4'h9) begin
      n_err++;
      $display("FAIL collide_wf dut1: got valid=%b data=%h, want 1 9", rvalid[1], rdata[1]);
    end
    read_en = 1'b1; read_addr = 8'd5;
    tick();
    n_vec++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 4'h9) begin
      n_err++;
      $display("FAIL collide_after dut0: got valid=%b data=%h, want 1 9", rvalid[0], rdata[0]);
    end
    idle_inputs();
    tick();
    n_vec++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 4'h9) begin
      n_err++;
      $display("FAIL collide_after dut1: got valid=%b data=%h, want 1 9", rvalid[1], rdata[1]);
    end
  endtask

  // Out-of-range on DEPTH 6: error pulses, zero-valued reads, and untouched contents.
  task automatic test_out_of_range();
    // Contents of dut2 left behind by the earlier tests.
    logic [3:0] exp_mem [6];
    exp_mem = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9};
    write_en = 1'b1; write_addr = 8'd6; write_data = 4'h7;
    tick();
    n_vec++;
    if (aerr[2] !== 1'b1) begin
      n_err++;
      $display("FAIL oor_wr_err dut2: got %b, want 1", aerr[2]);
    end
    write_en = 1'b0;
    tick();
    n_vec++;
    if (aerr[2] !== 1'b0) begin
      n_err++;
      $display("FAIL oor_pulse dut2: got %b, want 0", aerr[2]);
    end
    for (int a = 6; a < 8; a++) begin
      read_en = 1'b1; read_addr = 8'(a);
      tick();
      n_vec++;
      if (aerr[2] !== 1'b1 || rvalid[2] !== 1'b1 || rdata[2] !== 4'h0) begin
        n_err++;
        $display("FAIL oor_rd dut2 addr%0d: got err=%b valid=%b data=%h, want 1 1 0",
                 a, aerr[2], rvalid[2], rdata[2]);
      end
    end
    for (int a = 0; a < 6; a++) begin
      read_en = 1'b1; read_addr = 8'(a);
      tick();
      n_vec++;
      if (aerr[2] !== 1'b0 || rvalid[2] !== 1'b1 || rdata[2] !== exp_mem[a]) begin
        n_err++;
        $display("FAIL oor_keep dut2 addr%0d: got err=%b valid=%b data=%h, want 0 1 %h",
                 a, aerr[2], rvalid[2], rdata[2], exp_mem[a]);
      end
    end
    idle_inputs();
    tick();
  endtask

  // Restart the sweep mid-way, then check that requests while busy have no effect.
  task automatic test_busy_requests();
    int cnt [NDUT];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) cnt[d] = 0;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < NDUT; d++) begin
        if (busy[d] === 1'b1) cnt[d]++;
        n_vec++;
        if (rvalid[d] !== 1'b0 || aerr[d] !== 1'b0) begin
          n_err++;
          $display("FAIL busy_ignore dut%0d step%0d: got valid=%b err=%b, want 0 0", d, i, rvalid[d], aerr[d]);
        end
      end
      if (i < 5) begin
        write_en = 1'b1; read_en = 1'b1; write_data = 4'hF;
        write_addr = (i % 2 == 1) ? 8'd9 : 8'd2;
        read_addr  = write_addr;
      end else begin
        idle_inputs();
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) begin
      n_vec++;
      if (cnt[d] != int'(dep_of(d))) begin
        n_err++;
        $display("FAIL restart_busy_len dut%0d: got %0d cycles, want %0d", d, cnt[d], dep_of(d));
      end
    end
    read_en = 1'b1; read_addr = 8'd2;
    tick();
    for (int d = 0; d < NDUT; d += 2) begin
      n_vec++;
      if (rvalid[d] !== 1'b1 || rdata[d] !== 4'h0) begin
        n_err++;
        $display("FAIL busy_nowrite dut%0d: got valid=%b data=%h, want 1 0", d, rvalid[d], rdata[d]);
      end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 4'h0) begin
      n_err++;
      $display("FAIL busy_nowrite dut1: got valid=%b data=%h, want 1 0", rvalid[1], rdata[1]);
    end
  endtask

  // Random traffic, including occasional resets, compared against the model every cycle.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 60) == 0);
      write_en   = ($urandom_range(0, 1) == 1);
      read_en    = ($urandom_range(0, 1) == 1);
      write_addr = 8'($urandom_range(0, 9));
      read_addr  = ($urandom_range(0, 3) == 0) ? write_addr : 8'($urandom_range(0, 9));
      write_data = 4'($urandom_range(0, 15));
      tick();
      for (int d = 0; d < NDUT; d++) begin
        n_vec++;
        if (rvalid[d] !== e_valid[d] || rdata[d] !== e_data[d] ||
            busy[d] !== e_busy[d] || aerr[d] !== e_err[d]) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d: got v=%b d=%h b=%b e=%b, want v=%b d=%h b=%b e=%b",
                   d, c, rvalid[d], rdata[d], busy[d], aerr[d],
                   e_valid[d], e_data[d], e_busy[d], e_err[d]);
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_rw();
    test_stream_lat2();
    test_collision();
    test_out_of_range();
    test_busy_requests();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
